// File: rtl/square_pkg.sv
// Shared types and constants for the squarer and its square-root companion benches.
package square_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sq_state_t;

    localparam int SQ_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/square_calculator.sv
// Shift-add squarer: result valid WIDTH cycles after accept, one result per WIDTH+2 cycles.
// Backpressure: result held in DONE until dout_ready; new roots accepted only in IDLE.
module square_calculator
    import square_pkg::*;
#(
    parameter int WIDTH = SQ_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic [WIDTH-1:0]     din,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [2*WIDTH-1:0]   dout
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    sq_state_t            state_q,  state_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [2*WIDTH-1:0]   acc_sum;

    // Partial-product add; cannot overflow since (2^W-1)^2 < 2^(2W).
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (din_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, din};
                    mplier_d = din;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                // Fixed latency: run all WIDTH steps even once mplier is zero.
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (dout_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign din_ready  = (state_q == IDLE);
    assign dout_valid = (state_q == DONE);
    assign dout       = acc_q;

endmodule

// File: tb/tb_square_calculator.sv
// Directed bench for square_calculator (WIDTH=4) with a reference integer square root for round-trip.
module tb_square_calculator;
    import square_pkg::*;

    localparam int W = SQ_WIDTH_DEFAULT;

    logic           clk = 1'b0;
    logic           rst;
    logic           din_valid;
    logic           din_ready;
    logic [W-1:0]   din;
    logic           dout_valid;
    logic           dout_ready;
    logic [2*W-1:0] dout;

    int n_vec = 0;
    int n_err = 0;

    square_calculator #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din        (din),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // One full transaction; stall>0 holds dout_ready low that many cycles after dout_valid rises
    // while offering a competing root that must be ignored.
    task automatic run_one(input logic [W-1:0] d, input int stall);
        logic [2*W-1:0] exp;
        int cyc;
        exp = (2*W)'(d) * (2*W)'(d);
        @(negedge clk);
        chk("din_ready_idle", din_ready, 1);
        dout_ready = (stall == 0);
        din        = d;
        din_valid  = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = ~d;
        cyc = 0;
        @(negedge clk);
        while (!dout_valid && cyc < 20) begin
            chk("din_ready_busy", din_ready, 0);
            cyc++;
            @(negedge clk);
        end
        chk("latency", cyc, W);
        chk("dout_valid_rise", dout_valid, 1);
        chk("din_ready_done", din_ready, 0);
        for (int s = 0; s < stall; s++) begin
            chk("stall_dout", dout, exp);
            chk("stall_valid", dout_valid, 1);
            din       = 4'd7;
            din_valid = 1'b1;
            @(negedge clk);
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        chk("dout", dout, exp);
        chk("sqrt_round_trip", isqrt(int'(dout)), d);
        @(posedge clk);
        #1;
        chk("post_valid", dout_valid, 0);
        chk("post_din_ready", din_ready, 1);
        chk("dout_hold", dout, exp);
    endtask

    initial begin
        int seen;
        rst        = 1'b1;
        din_valid  = 1'b0;
        din        = '0;
        dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_din_ready", din_ready, 1);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        @(negedge clk);
        rst = 1'b0;

        run_one(4'd0, 0);
        run_one(4'd15, 0);
        run_one(4'd1, 0);
        run_one(4'd10, 0);

        run_one(4'd3, 3);

        // Reset during the second CALC cycle must drop the result immediately.
        @(negedge clk);
        din       = 4'd12;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_din_ready", din_ready, 1);
        chk("midrst_dout_valid", dout_valid, 0);
        chk("midrst_dout", dout, 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (dout_valid) seen = 1;
        end
        chk("midrst_no_result", seen, 0);
        run_one(4'd5, 0);

        for (int i = 0; i < (1 << W); i++) begin
            run_one(W'(i), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/square_calculator.md
Name: square_calculator

Overview:
Sequential shift-add squarer: accepts an unsigned WIDTH-bit root and returns its exact 2*WIDTH-bit square. It is the inverse companion of the square-root extractor and generates radicands from known roots. Valid/ready handshakes on both sides. It also closes a round-trip self-check: root -> square_calculator -> square-root extractor -> same root.

Parameters:
WIDTH, 4, bit width of the input root; the output square is 2*WIDTH bits.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
din_valid  input  1  din holds a valid root
din_ready  output  1  block can accept a root; high only in IDLE
din  input  WIDTH  unsigned root
dout_valid  output  1  dout holds a valid square; high only in DONE
dout_ready  input  1  downstream accepts dout
dout  output  2*WIDTH  unsigned square din*din

Behaviour:
- Reset, asynchronous and active-high: state=IDLE, acc=0, mcand=0, mplier=0, cnt=0, dout=0, dout_valid=0, din_ready=1.
- din_ready and dout_valid are decoded combinationally from the state register; they have no other logic.
- State IDLE:
  - On the edge where din_valid && din_ready: mcand <= {WIDTH'0, din}, mplier <= din, acc <= 0, cnt <= 0, state -> CALC.
  - Otherwise hold.
- State CALC, exactly WIDTH cycles:
  - Each edge: if mplier[0], acc <= acc + mcand; then mcand <= mcand << 1, mplier <= mplier >> 1, cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1: state -> DONE.
  - No early exit when mplier becomes 0, so latency is fixed.
- State DONE:
  - dout = acc is driven and held stable while dout_valid=1 && dout_ready=0.
  - On the edge where dout_ready=1: state -> IDLE.
  - dout keeps its last value after the transfer; it is only meaningful while dout_valid=1.
- Latency: input accepted at edge T0; dout_valid rises after edge T0+WIDTH. Minimum throughput is one result every WIDTH+2 cycles, with zero backpressure.
- Width rules:
  - acc and mcand are 2*WIDTH bits.
  - The sum never overflows because (2^WIDTH-1)^2 < 2^(2*WIDTH).
  - cnt is $clog2(WIDTH)+1 bits.
- Boundary conditions:
  - din_valid while in CALC or DONE: ignored (din_ready=0); din is not sampled.
  - dout_ready high in IDLE or CALC: no effect.
  - dout_ready held high in DONE and din_valid high on the following IDLE cycle: back-to-back accept with no lost data.
  - din=0: dout=0. din=all-ones: dout=(2^WIDTH-1)^2.
  - rst asserted in any state: the in-flight result is discarded immediately and the block returns to IDLE with reset values. No partial result is ever presented.
- No X on outputs after reset. Internal registers are never left uninitialised.

Decomposition:
- Package square_pkg:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} sq_state_t.
  - Shared default-width constant SQ_WIDTH_DEFAULT=4, also used by the extractor benches.
- No sub-module. The shift-add datapath is a single always_ff plus a small combinational adder; splitting it out adds nothing.
- Target size: roughly 120-160 lines.

Test Plan:
All scenarios use WIDTH=4.
1. Reset then din=0, din_valid pulse -> dout_valid rises 4 cycles after accept; dout=8'd0; din_ready low for the 5 cycles until the transfer.
2. din=15 -> dout=8'd225. din=1 -> dout=8'd1. din=10 -> dout=8'd100. All with dout_ready held high; next accept occurs on the cycle after each transfer.
3. Backpressure: din=3, dout_ready low for 3 cycles after dout_valid rises -> dout stays 8'd9 and dout_valid stays 1 throughout; single transfer on release; din=7 offered during the stall is not accepted.
4. Reset mid-operation: din=12 accepted, rst asserted for 1 cycle during the 2nd CALC cycle -> outputs return to reset values immediately; dout_valid never rises for 12. A following din=5 yields 8'd25.
5. Exhaustive and round-trip:
   - All din 0..15 back-to-back -> each dout equals din*din.
   - Feed each dout into the square-root extractor -> recovered root equals the original din.
